// File: rtl/ifq_fetch.sv
// Instruction fetch queue: circular buffer of {instr, pc} fed by the I-cache, drained by decode.
// Optional same-cycle empty-queue bypass enabled by defining IFQ_BYPASS_EN.
//
// purpose     : fetch PC generation plus a DEPTH-entry instruction queue between I-cache and decoder
// latency     : push visible at the head one cycle later (zero cycles when bypassing an empty queue)
// backpressure: fetch request drops when the queue is full and decode is not dequeuing; misses stall indefinitely
module ifq_fetch #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] pc_out,
   output logic        icache_rd_en,
   input  logic [31:0] icache_dout,
   input  logic        icache_valid,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   input  logic        deq,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        empty,
   output logic        full
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
   localparam logic [31:0] NOP      = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   entry_t        r_mem [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [AW:0]   r_count;
   logic [31:0]   r_pc;

   logic   w_empty_q;
   logic   w_full_q;
   logic   w_rd_en;
   logic   w_push;
   logic   w_pop;
   logic   w_bypass;
   logic   w_store;
   entry_t w_head;

   assign w_empty_q = (r_count == '0);
   assign w_full_q  = (r_count == CNT_FULL);

   // rst_n gates the request so nothing is fetched while reset is held
   assign w_rd_en = rst_n & ~flush & (~w_full_q | deq);
   assign w_push  = w_rd_en & icache_valid;
   assign w_pop   = deq & ~w_empty_q & ~flush;

`ifdef IFQ_BYPASS_EN
   assign w_bypass = w_push & w_empty_q;
`else
   assign w_bypass = 1'b0;
`endif

   // a bypassed word consumed in the same cycle never occupies an entry
   assign w_store = w_push & ~(w_bypass & deq);

   assign w_head = r_mem[r_rd_ptr];

   always_comb begin
      instr    = NOP;
      instr_pc = 32'h0;
      if (!w_empty_q) begin
         instr    = w_head.instr;
         instr_pc = w_head.pc;
      end else if (w_bypass) begin
         instr    = icache_dout;
         instr_pc = r_pc;
      end
   end

   assign empty        = w_empty_q & ~w_bypass;
   assign full         = w_full_q;
   assign icache_rd_en = w_rd_en;
   assign pc_out       = r_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_pc     <= PC_RESET;
      end else if (flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_pc     <= flush_pc;
      end else begin
         if (w_push) begin
            r_pc <= r_pc + 32'd4;
         end
         if (w_store) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_store, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // entry payload is never reset; only the count/pointers define validity
   always_ff @(posedge clk) begin
      if (w_store) begin
         r_mem[r_wr_ptr] <= '{instr: icache_dout, pc: r_pc};
      end
   end

endmodule

// File: tb/tb_ifq_fetch.sv
// Directed plus randomised bench for ifq_fetch with a queue-based scoreboard of expected head entries.
module tb_ifq_fetch;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] PC_RESET = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] i;
      logic [31:0] p;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_out;
   logic        icache_rd_en;
   logic [31:0] icache_dout;
   logic        icache_valid;
   logic        flush;
   logic [31:0] flush_pc;
   logic        deq;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        empty;
   logic        full;

   logic        tb_force;
   logic [31:0] tb_force_val;

   int          checks = 0;
   int          errors = 0;
   ent_t        sb[$];
   logic [31:0] mpc;

   always #5 clk = ~clk;

   function automatic logic [31:0] cache_word(input logic [31:0] pc);
      return {pc[15:0] ^ 16'hBEEF, pc[15:0]};
   endfunction

   assign icache_dout = tb_force ? tb_force_val : cache_word(pc_out);

   ifq_fetch #(.DEPTH(DEPTH), .PC_RESET(PC_RESET)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pc_out       (pc_out),
      .icache_rd_en (icache_rd_en),
      .icache_dout  (icache_dout),
      .icache_valid (icache_valid),
      .flush        (flush),
      .flush_pc     (flush_pc),
      .deq          (deq),
      .instr        (instr),
      .instr_pc     (instr_pc),
      .empty        (empty),
      .full         (full)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Called at posedge+1; checks at the following negedge, then advances the model over the next edge.
   task automatic step(input logic v, input logic d, input logic f, input logic [31:0] fpc);
      logic        exp_en;
      logic        push;
      logic        byp;
      ent_t        word;
      icache_valid = v;
      deq          = d;
      flush        = f;
      flush_pc     = fpc;
      #4;
      exp_en = !f && (sb.size() < DEPTH || d);
      push   = exp_en && v;
      byp    = 1'b0;
`ifdef IFQ_BYPASS_EN
      byp = push && (sb.size() == 0);
`endif
      word = '{i: (tb_force ? tb_force_val : cache_word(mpc)), p: mpc};
      chk("rd_en",  {31'b0, icache_rd_en}, {31'b0, exp_en});
      chk("pc_out", pc_out, mpc);
      chk("full",   {31'b0, full}, {31'b0, (sb.size() == DEPTH)});
      if (!(f && sb.size() != 0)) begin
         chk("empty", {31'b0, empty}, {31'b0, (sb.size() == 0 && !byp)});
         if (sb.size() != 0) begin
            chk("head_instr", instr,    sb[0].i);
            chk("head_pc",    instr_pc, sb[0].p);
         end else if (byp) begin
            chk("bypass_instr", instr,    word.i);
            chk("bypass_pc",    instr_pc, word.p);
         end else begin
            chk("nop_instr", instr,    NOP);
            chk("nop_pc",    instr_pc, 32'h0);
         end
      end
      @(posedge clk);
      if (f) begin
         sb.delete();
         mpc = fpc;
      end else begin
         if (!(byp && d)) begin
            if (d && sb.size() != 0) void'(sb.pop_front());
            if (push) sb.push_back(word);
         end
         if (push) mpc = mpc + 32'd4;
      end
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_empty"}, {31'b0, empty},        32'd1);
      chk({tag, "_full"},  {31'b0, full},         32'd0);
      chk({tag, "_rden"},  {31'b0, icache_rd_en}, 32'd0);
      chk({tag, "_pc"},    pc_out,   PC_RESET);
      chk({tag, "_instr"}, instr,    NOP);
      chk({tag, "_ipc"},   instr_pc, 32'h0);
   endtask

   initial begin
      rst_n        = 1'b0;
      icache_valid = 1'b1;
      deq          = 1'b0;
      flush        = 1'b0;
      flush_pc     = 32'h0;
      tb_force     = 1'b0;
      tb_force_val = 32'h0;
      mpc          = PC_RESET;
      #2;
      check_reset_state("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // fill to full, then hold with no dequeue
      for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("fill_pc16", pc_out, 32'd16);

      // full-throughput streaming at count=DEPTH
      for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("stream_full", {31'b0, full}, 32'd1);

      // drain to two entries, then redirect
      step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);

      // drain then dequeue against an empty queue
      for (int k = 0; k < 2; k++) step(1'b0, 1'b1, 1'b0, 32'h0);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 32'h0);

      // push into an empty queue with deq asserted
      step(1'b0, 1'b0, 1'b1, 32'h0);
      tb_force     = 1'b1;
      tb_force_val = 32'h0050_0093;
      step(1'b1, 1'b1, 1'b0, 32'h0);
      tb_force     = 1'b0;
      step(1'b0, 1'b1, 1'b0, 32'h0);

      // three entries, miss stall, then asynchronous reset mid-stall
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      rst_n = 1'b0;
      #1;
      check_reset_state("midreset");
      sb.delete();
      mpc = PC_RESET;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);

      for (int k = 0; k < 300; k++) begin
         step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 24) == 0), {22'h0, 8'($urandom_range(0, 255)), 2'b00});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
